hnoc_switch_rr: RTL and testbench

//  Single-clock, parametrised N-port NoC switch node: NUM_PE local PE ports plus one uplink port.

---
 rtl/hnoc_switch_rr.sv | 159 +++++++++++++++
 tb/tb_hnoc_switch_rr.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hnoc_switch_rr.sv
// hnoc_switch_rr: NoC switch node with NUM_PE local ports plus one uplink, per-input FIFOs
// and per-output round-robin arbiters. Define HNOC_SW_PERF_EN to add flit/drop counters.
module hnoc_switch_rr #(
   parameter int DataWidth  = 32,
   parameter int AddrWidth  = 4,
   parameter int NUM_PE     = 4,
   parameter int BASE_ADDR  = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                                        i_clk,
   input  logic                                        i_reset,
   input  logic [(NUM_PE+1)*(DataWidth+AddrWidth)-1:0] i_pe_data,
   input  logic [NUM_PE:0]                             i_pe_data_valid,
   output logic [NUM_PE:0]                             o_pe_data_ready,
   output logic [(NUM_PE+1)*(DataWidth+AddrWidth)-1:0] o_pe_data,
   output logic [NUM_PE:0]                             o_pe_data_valid,
   input  logic [NUM_PE:0]                             i_pe_data_ready
`ifdef HNOC_SW_PERF_EN
   ,
   output logic [31:0]                                 o_flit_count,
   output logic [15:0]                                 o_drop_count
`endif
);
   localparam int P  = NUM_PE + 1;
   localparam int FW = DataWidth + AddrWidth;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int SW = $clog2(P);

   logic          r_run;
   logic [P-1:0]  w_empty;
   logic [P-1:0]  w_full;
   logic [P-1:0]  w_push;
   logic [P-1:0]  w_pop;
   logic [P-1:0]  w_drop;
   logic [P-1:0]  w_req;
   logic [FW-1:0] w_head    [P];
   logic [SW-1:0] w_dest    [P];
   logic [P-1:0]  w_gnt_mat [P];

   // Holds ready low until the first edge after reset release.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) r_run <= 1'b0;
      else          r_run <= 1'b1;
   end

   assign o_pe_data_ready = r_run ? ~w_full : '0;
   assign w_push          = i_pe_data_valid & o_pe_data_ready;

   genvar gi;
   generate
      for (gi = 0; gi < P; gi++) begin : g_in
         logic [FW-1:0]        r_mem [FIFO_DEPTH];
         logic [PW:0]          r_wr_ptr;
         logic [PW:0]          r_rd_ptr;
         logic [AddrWidth-1:0] w_addr;
         logic                 w_local;

         always_ff @(posedge i_clk) begin
            if (w_push[gi]) r_mem[r_wr_ptr[PW-1:0]] <= i_pe_data[gi*FW +: FW];
         end

         always_ff @(posedge i_clk or negedge i_reset) begin
            if (!i_reset) begin
               r_wr_ptr <= '0;
               r_rd_ptr <= '0;
            end else begin
               if (w_push[gi]) r_wr_ptr <= r_wr_ptr + 1'b1;
               if (w_pop[gi])  r_rd_ptr <= r_rd_ptr + 1'b1;
            end
         end

         assign w_empty[gi] = (r_wr_ptr == r_rd_ptr);
         assign w_full[gi]  = ((r_wr_ptr - r_rd_ptr) == (PW+1)'(FIFO_DEPTH));
         assign w_head[gi]  = r_mem[r_rd_ptr[PW-1:0]];
         assign w_addr      = w_head[gi][FW-1 -: AddrWidth];
         assign w_local     = (int'(w_addr) >= BASE_ADDR) && (int'(w_addr) < BASE_ADDR + NUM_PE);
         assign w_dest[gi]  = w_local ? SW'(int'(w_addr) - BASE_ADDR) : SW'(NUM_PE);

         // An uplink flit that is not for this subtree has nowhere to go: discard it.
         if (gi == NUM_PE) begin : g_up
            assign w_drop[gi] = !w_empty[gi] && !w_local;
         end else begin : g_pe
            assign w_drop[gi] = 1'b0;
         end
         assign w_req[gi] = !w_empty[gi] && !w_drop[gi];
      end

      for (gi = 0; gi < P; gi++) begin : g_out
         logic          r_valid;
         logic [FW-1:0] r_data;
         logic [SW-1:0] r_rr;
         logic          w_free;
         logic          w_gnt;
         logic [SW-1:0] w_gnt_idx;
         int            w_idx;

         assign w_free = !r_valid || i_pe_data_ready[gi];

         always_comb begin
            w_gnt     = 1'b0;
            w_gnt_idx = '0;
            w_idx     = 0;
            for (int off = 0; off < P; off++) begin
               w_idx = (int'(r_rr) + off) % P;
               if (!w_gnt && w_free && w_req[w_idx] && (w_dest[w_idx] == SW'(gi))) begin
                  w_gnt     = 1'b1;
                  w_gnt_idx = SW'(w_idx);
               end
            end
         end

         assign w_gnt_mat[gi] = w_gnt ? (P'(1) << w_gnt_idx) : '0;

         always_ff @(posedge i_clk or negedge i_reset) begin
            if (!i_reset) begin
               r_valid <= 1'b0;
               r_data  <= '0;
               r_rr    <= '0;
            end else if (w_gnt) begin
               r_valid <= 1'b1;
               r_data  <= w_head[w_gnt_idx];
               r_rr    <= (w_gnt_idx == SW'(P-1)) ? '0 : w_gnt_idx + 1'b1;
            end else if (w_free) begin
               r_valid <= 1'b0;
            end
         end

         assign o_pe_data_valid[gi]     = r_valid;
         assign o_pe_data[gi*FW +: FW] = r_data;
      end
   endgenerate

   // Each head has a single destination, so at most one grant row hits any input column.
   always_comb begin
      w_pop = w_drop;
      for (int j = 0; j < P; j++) w_pop = w_pop | w_gnt_mat[j];
   end

`ifdef HNOC_SW_PERF_EN
   logic [31:0] r_flit_count;
   logic [15:0] r_drop_count;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_flit_count <= '0;
         r_drop_count <= '0;
      end else begin
         r_flit_count <= r_flit_count + 32'($countones(o_pe_data_valid & i_pe_data_ready));
         if (w_drop[NUM_PE] && (r_drop_count != 16'hFFFF)) r_drop_count <= r_drop_count + 1'b1;
      end
   end

   assign o_flit_count = r_flit_count;
   assign o_drop_count = r_drop_count;
`else
   // Counters absent: dropped uplink flits are still popped, just not counted.
`endif

endmodule

// File: tb/tb_hnoc_switch_rr.sv
// Testbench for hnoc_switch_rr: directed vectors, corner sequences and random traffic
// checked every cycle against a queue-based reference model.
module tb_hnoc_switch_rr;
   localparam int DW    = 32;
   localparam int AW    = 4;
   localparam int NPE   = 4;
   localparam int BASE  = 0;
   localparam int DEPTH = 4;
   localparam int P     = NPE + 1;
   localparam int FW    = DW + AW;

   logic            i_clk = 1'b0;
   logic            i_reset;
   logic [P*FW-1:0] i_pe_data;
   logic [P*FW-1:0] o_pe_data;
   logic [P-1:0]    i_pe_data_valid;
   logic [P-1:0]    o_pe_data_ready;
   logic [P-1:0]    o_pe_data_valid;
   logic [P-1:0]    i_pe_data_ready;
`ifdef HNOC_SW_PERF_EN
   logic [31:0]     o_flit_count;
   logic [15:0]     o_drop_count;
`endif

   int n_total = 0;
   int n_bad   = 0;

   // reference model: one queue per input, one holding register per output
   logic [FW-1:0] mq [P][$];
   logic          m_ov [P];
   logic [FW-1:0] m_od [P];
   int            m_rr [P];
   logic          m_run;
   logic [31:0]   m_flits;
   logic [15:0]   m_drops;

   typedef struct {
      int          port;
      logic [3:0]  addr;
      logic [31:0] pay;
      int          exp_port;
   } vec_t;
   vec_t vt [10];

   hnoc_switch_rr #(
      .DataWidth (DW),
      .AddrWidth (AW),
      .NUM_PE    (NPE),
      .BASE_ADDR (BASE),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_pe_data      (i_pe_data),
      .i_pe_data_valid(i_pe_data_valid),
      .o_pe_data_ready(o_pe_data_ready),
      .o_pe_data      (o_pe_data),
      .o_pe_data_valid(o_pe_data_valid),
      .i_pe_data_ready(i_pe_data_ready)
`ifdef HNOC_SW_PERF_EN
      ,
      .o_flit_count   (o_flit_count),
      .o_drop_count   (o_drop_count)
`endif
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [FW-1:0] mk(input logic [3:0] a, input logic [31:0] d);
      return {a, d};
   endfunction

   function automatic int route(input logic [FW-1:0] f);
      int a;
      a = int'(f >> DW);
      if (a >= BASE && a < BASE + NPE) return a - BASE;
      return NPE;
   endfunction

   function automatic logic [P*FW-1:0] rand_bus();
      logic [P*FW-1:0] b;
      b = '0;
      for (int i = 0; i < 6; i++) b = (b << 32) | (P*FW)'($urandom);
      return b;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < P; k++) begin
         mq[k].delete();
         m_ov[k] = 1'b0;
         m_od[k] = '0;
         m_rr[k] = 0;
      end
      m_run   = 1'b0;
      m_flits = '0;
      m_drops = '0;
   endtask

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_step();
      bit acc [P];
      bit pop [P];
      bit has [P];
      int dest [P];
      int hs;
      hs = 0;
      for (int k = 0; k < P; k++) begin
         acc[k]  = m_run && i_pe_data_valid[k] && (mq[k].size() < DEPTH);
         pop[k]  = 1'b0;
         has[k]  = (mq[k].size() > 0);
         dest[k] = has[k] ? route(mq[k][0]) : -1;
         if (k == NPE && has[k] && dest[k] == NPE) begin
            pop[k] = 1'b1;
            has[k] = 1'b0;
            if (m_drops != 16'hFFFF) m_drops++;
         end
      end
      for (int j = 0; j < P; j++) if (m_ov[j] && i_pe_data_ready[j]) hs++;
      m_flits += 32'(hs);
      for (int j = 0; j < P; j++) begin
         if (!m_ov[j] || i_pe_data_ready[j]) begin
            int g;
            g = -1;
            for (int off = 0; off < P; off++) begin
               int kk;
               kk = (m_rr[j] + off) % P;
               if (g < 0 && has[kk] && dest[kk] == j) g = kk;
            end
            if (g >= 0) begin
               m_ov[j] = 1'b1;
               m_od[j] = mq[g][0];
               pop[g]  = 1'b1;
               has[g]  = 1'b0;
               m_rr[j] = (g + 1) % P;
            end else begin
               m_ov[j] = 1'b0;
            end
         end
      end
      for (int k = 0; k < P; k++) begin
         if (pop[k]) void'(mq[k].pop_front());
         if (acc[k]) mq[k].push_back(i_pe_data[k*FW +: FW]);
      end
      m_run = 1'b1;
   endtask

   task automatic compare();
      logic [P-1:0]    ev;
      logic [P-1:0]    er;
      logic [P*FW-1:0] ed;
      logic [P*FW-1:0] ad;
      for (int j = 0; j < P; j++) begin
         ev[j]          = m_ov[j];
         er[j]          = m_run && (mq[j].size() < DEPTH);
         ed[j*FW +: FW] = m_ov[j] ? m_od[j] : '0;
         ad[j*FW +: FW] = m_ov[j] ? o_pe_data[j*FW +: FW] : '0;
      end
      check("m_valid", o_pe_data_valid, ev);
      check("m_ready", o_pe_data_ready, er);
      check("m_data", ad, ed);
`ifdef HNOC_SW_PERF_EN
      check("m_flits", o_flit_count, m_flits);
      check("m_drops", o_drop_count, m_drops);
`endif
   endtask

   task automatic cycle();
      if (i_reset) model_step();
      else         model_reset();
      @(posedge i_clk);
      #1;
      compare();
   endtask

   task automatic do_reset();
      i_reset = 1'b0;
      #1;
      check("arst_valid", o_pe_data_valid, '0);
      check("arst_ready", o_pe_data_ready, '0);
      check("arst_data", o_pe_data, '0);
      cycle();
      cycle();
      i_reset = 1'b1;
      cycle();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int drops_exp;
      int srcs [3];
      int n_acc;
      int got;
      int idx;
      bit acc_now;
      bit exp;
`ifdef HNOC_SW_PERF_EN
      logic [31:0] fc0;
`endif
      drops_exp = 0;
      srcs = '{0, 1, 3};

      vt[0] = '{0, 4'h2, 32'hDEADBEEF, 2};
      vt[1] = '{0, 4'h9, 32'h00000009, 4};
      vt[2] = '{4, 4'h9, 32'h99999999, -1};
      vt[3] = '{4, 4'h1, 32'h11110001, 1};
      vt[4] = '{3, 4'h3, 32'h33333333, 3};
      vt[5] = '{1, 4'h0, 32'h10000000, 0};
      vt[6] = '{2, 4'h4, 32'h24242424, 4};
      vt[7] = '{4, 4'hF, 32'hFFFF0000, -1};
      vt[8] = '{4, 4'h0, 32'h40404040, 0};
      vt[9] = '{4, 4'h3, 32'h43434343, 3};

      i_reset         = 1'b0;
      i_pe_data       = '0;
      i_pe_data_valid = '0;
      i_pe_data_ready = '1;
      model_reset();

      // reset held with random inputs
      for (int c = 0; c < 4; c++) begin
         i_pe_data       = rand_bus();
         i_pe_data_valid = P'($urandom);
         i_pe_data_ready = P'($urandom);
         cycle();
         check("rst_valid", o_pe_data_valid, '0);
         check("rst_ready", o_pe_data_ready, '0);
         check("rst_data", o_pe_data, '0);
      end
      i_pe_data_valid = '0;
      i_pe_data_ready = '1;
      i_reset         = 1'b1;
      cycle();
      check("rel_ready", o_pe_data_ready, {P{1'b1}});

      // single-flit routing vectors
      for (int i = 0; i < 10; i++) begin
         i_pe_data = '0;
         i_pe_data[vt[i].port*FW +: FW] = mk(vt[i].addr, vt[i].pay);
         i_pe_data_valid = P'(1) << vt[i].port;
         cycle();
         check("vec_lat", o_pe_data_valid, '0);
         i_pe_data_valid = '0;
         cycle();
         if (vt[i].exp_port < 0) begin
            drops_exp++;
            check("vec_drop_valid", o_pe_data_valid, '0);
`ifdef HNOC_SW_PERF_EN
            check("vec_drop_cnt", o_drop_count, drops_exp);
`endif
         end else begin
            check("vec_valid", o_pe_data_valid, P'(1) << vt[i].exp_port);
            check("vec_data", o_pe_data[vt[i].exp_port*FW +: FW], mk(vt[i].addr, vt[i].pay));
         end
         $display("vec %0d: port %0d addr %0h -> out %0d", i, vt[i].port, vt[i].addr, vt[i].exp_port);
         cycle();
      end

      // three inputs contending for port 2 from reset pointer state
      do_reset();
      for (int c = 0; c < 16; c++) begin
         i_pe_data       = '0;
         i_pe_data_valid = '0;
         if (c < 4) begin
            for (int s = 0; s < 3; s++) begin
               i_pe_data[srcs[s]*FW +: FW] = mk(4'h2, {16'hA5A5, 8'(srcs[s]), 8'(c)});
               i_pe_data_valid[srcs[s]]    = 1'b1;
            end
         end
         cycle();
         exp = (c >= 1 && c <= 12);
         check("rr_valid", o_pe_data_valid[2], exp);
         if (exp) begin
            idx = c - 1;
            check("rr_data", o_pe_data[2*FW +: FW], mk(4'h2, {16'hA5A5, 8'(srcs[idx%3]), 8'(idx/3)}));
            $display("rr flit %0d: src %0d seq %0d", idx, srcs[idx%3], idx/3);
         end
      end

      // backpressure on port 2 while port 0 streams
      i_pe_data_ready = 5'b11011;
      n_acc = 0;
      for (int c = 0; c < 20; c++) begin
         i_pe_data       = '0;
         i_pe_data[0 +: FW] = mk(4'h2, {16'hB00B, 16'(n_acc)});
         i_pe_data_valid = 5'b00001;
         acc_now = o_pe_data_ready[0];
         cycle();
         if (acc_now) n_acc++;
      end
      check("hol_accepted", n_acc, DEPTH + 1);
      check("hol_ready", o_pe_data_ready[0], 1'b0);
      i_pe_data_valid = '0;
      i_pe_data_ready = '1;
      got = 0;
      for (int t = 0; t < 30 && got < DEPTH + 1; t++) begin
         if (o_pe_data_valid[2]) begin
            check("hol_data", o_pe_data[2*FW +: FW], mk(4'h2, {16'hB00B, 16'(got)}));
            $display("hol flit %0d delivered", got);
            got++;
         end
         cycle();
      end
      check("hol_count", got, DEPTH + 1);

      // three outputs handshake in the same cycle
      i_pe_data = '0;
      i_pe_data[0*FW +: FW] = mk(4'h1, 32'h11111111);
      i_pe_data[1*FW +: FW] = mk(4'h2, 32'h22222222);
      i_pe_data[3*FW +: FW] = mk(4'h3, 32'h33333333);
      i_pe_data_valid = 5'b01011;
      cycle();
      i_pe_data_valid = '0;
      cycle();
      check("par_valid", o_pe_data_valid, 5'b01110);
`ifdef HNOC_SW_PERF_EN
      fc0 = o_flit_count;
      cycle();
      check("par_flits", o_flit_count, fc0 + 32'd3);
`else
      cycle();
`endif

      // random traffic with a reset in the middle
      for (int c = 0; c < 400; c++) begin
         if (c == 200) do_reset();
         for (int k = 0; k < P; k++) begin
            logic [3:0] a;
            a = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, NPE));
            i_pe_data[k*FW +: FW] = mk(a, $urandom);
            i_pe_data_valid[k]    = ($urandom_range(0, 9) < 6);
            i_pe_data_ready[k]    = ($urandom_range(0, 3) != 0);
         end
         cycle();
      end
      i_pe_data_valid = '0;
      i_pe_data_ready = '1;
      repeat (20) cycle();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
